parity_sum_checker: RTL and testbench

- Receiving-end checker for the parity-predicted ripple adder chain.
- Consumes each adder result word bit-serially, LSB first, together with the parity predicted by the adder stages.
- Recomputes the actual parity of the sum, compares it with the prediction and reports a per-word mismatch over a valid/ready result handshake.
- Maintains a saturating error counter and a sticky error flag for the fault-monitoring logic.

---
 rtl/parity_sum_checker.sv | 183 ++++++++++++++++++
 tb/tb_parity_sum_checker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_sum_checker.sv
// Bit-serial parity checker for the parity-predicted adder chain result words.
// Define PARITY_SUM_CHECKER_FIRST_ERR_EN to add the first_err_word capture.
module parity_sum_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sum_bit,
    input  logic             par_exp,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_err,
    output logic             res_par,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    input  logic             clr_sticky
`ifdef PARITY_SUM_CHECKER_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_word
`endif
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             acc_q, acc_d;
    logic             par_q, par_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    logic accept;
    logic last_bit;
    logic res_hs;
    logic err_hs;

    assign accept   = in_valid && in_ready;
    assign last_bit = (state_q == SHIFT) && (idx_q == LAST);
    assign res_hs   = res_valid && res_ready;
    assign err_hs   = res_hs && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (accept && last_bit) state_d = REPORT;
            end
            REPORT: begin
                if (res_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        res_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            SHIFT:   in_ready = 1'b1;
            REPORT: begin
                in_ready  = 1'b0;
                res_valid = 1'b1;
            end
            default: in_ready = 1'b1;
        endcase
    end

    // Parity accumulation; the result registers only change on the final bit.
    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        par_d = par_q;
        err_d = err_q;
        if (accept) begin
            if (state_q == IDLE) begin
                acc_d = sum_bit;
                idx_d = IDX_W'(1);
            end else begin
                acc_d = acc_q ^ sum_bit;
                idx_d = idx_q + 1'b1;
                if (last_bit) begin
                    par_d = acc_q ^ sum_bit;
                    err_d = (acc_q ^ sum_bit) != par_exp;
                    idx_d = '0;
                end
            end
        end
    end

    // An erroneous handshake beats a simultaneous clear.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (err_hs) begin
            sticky_d = 1'b1;
            if (clr_sticky) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clr_sticky) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            acc_q    <= 1'b0;
            par_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            par_q    <= par_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign res_par    = par_q;
    assign res_err    = err_q;
    assign err_cnt    = cnt_q;
    assign err_sticky = sticky_q;

`ifdef PARITY_SUM_CHECKER_FIRST_ERR_EN
    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] first_q, first_d;

    // Capture is armed whenever no error is pending or a clear is in flight.
    always_comb begin
        word_d  = word_q;
        first_d = first_q;
        if (res_hs) word_d = word_q + 1'b1;
        if (err_hs && (!sticky_q || clr_sticky)) begin
            first_d = word_q;
        end else if (clr_sticky && !err_hs) begin
            first_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            first_q <= '0;
        end else begin
            word_q  <= word_d;
            first_q <= first_d;
        end
    end

    assign first_err_word = first_q;
`endif

endmodule

// File: tb/tb_parity_sum_checker.sv
// Directed self-checking bench for parity_sum_checker (WIDTH=8, CNT_W=2).
module tb_parity_sum_checker;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             sum_bit;
    logic             par_exp;
    logic             res_valid;
    logic             res_ready;
    logic             res_err;
    logic             res_par;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;
    logic             clr_sticky;
`ifdef PARITY_SUM_CHECKER_FIRST_ERR_EN
    logic [CNT_W-1:0] first_err_word;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    parity_sum_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_bit   (sum_bit),
        .par_exp   (par_exp),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_err   (res_err),
        .res_par   (res_par),
        .err_cnt   (err_cnt),
        .err_sticky(err_sticky),
        .clr_sticky(clr_sticky)
`ifdef PARITY_SUM_CHECKER_FIRST_ERR_EN
        ,
        .first_err_word(first_err_word)
`endif
    );

    // Drives one word LSB first; returns at the negedge after the last beat.
    task automatic send(input logic [7:0] w, input logic p);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sum_bit  = w[i];
            par_exp  = p;
        end
        @(negedge clk);
        in_valid = 1'b0;
        sum_bit  = 1'b0;
        par_exp  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        sum_bit = 1'b0;
        par_exp = 1'b0;
        res_ready = 1'b1;
        clr_sticky = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b want 0", res_valid);
        else pass_cnt++;
        chk_cnt++;
        if (err_cnt !== 2'd0 || err_sticky !== 1'b0)
            $display("FAIL rst_err got cnt=%0d sticky=%b want 0/0", err_cnt, err_sticky);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_correct;
        send(8'h5A, 1'b0);
        chk_cnt++;
        if (res_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL correct_latency got v=%b rdy=%b want 1/0", res_valid, in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (res_par !== 1'b0 || res_err !== 1'b0)
            $display("FAIL correct_result got par=%b err=%b want 0/0", res_par, res_err);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL correct_release got v=%b rdy=%b want 0/1", res_valid, in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (err_cnt !== 2'd0 || err_sticky !== 1'b0)
            $display("FAIL correct_cnt got cnt=%0d sticky=%b want 0/0", err_cnt, err_sticky);
        else pass_cnt++;
    endtask

    // Gaps carry garbage bits and non-final beats carry a wrong par_exp.
    task automatic test_stall;
        logic [7:0] w;
        w = 8'h5A;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            sum_bit  = 1'b1;
            par_exp  = 1'b1;
            @(negedge clk);
            in_valid = 1'b1;
            sum_bit  = w[i];
            par_exp  = (i == WIDTH - 1) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk_cnt++;
        if (res_valid !== 1'b1 || res_par !== 1'b0 || res_err !== 1'b0)
            $display("FAIL stall_result got v=%b par=%b err=%b want 1/0/0",
                     res_valid, res_par, res_err);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_mismatch;
        send(8'h5A, 1'b1);
        chk_cnt++;
        if (res_err !== 1'b1 || res_par !== 1'b0)
            $display("FAIL mism_result got err=%b par=%b want 1/0", res_err, res_par);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (err_cnt !== 2'd1 || err_sticky !== 1'b1)
            $display("FAIL mism_cnt got cnt=%0d sticky=%b want 1/1", err_cnt, err_sticky);
        else pass_cnt++;
        send(8'h01, 1'b1);
        chk_cnt++;
        if (res_err !== 1'b0 || res_par !== 1'b1)
            $display("FAIL mism_ok_result got err=%b par=%b want 0/1", res_err, res_par);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (err_cnt !== 2'd1 || err_sticky !== 1'b1)
            $display("FAIL mism_ok_cnt got cnt=%0d sticky=%b want 1/1", err_cnt, err_sticky);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure;
        res_ready = 1'b0;
        send(8'h07, 1'b0);
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            sum_bit  = 1'b1;
            chk_cnt++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold_hs cyc %0d got v=%b rdy=%b want 1/0",
                         j, res_valid, in_ready);
            else pass_cnt++;
            chk_cnt++;
            if (res_err !== 1'b1 || res_par !== 1'b1 || err_cnt !== 2'd1)
                $display("FAIL bp_hold_data cyc %0d got err=%b par=%b cnt=%0d want 1/1/1",
                         j, res_err, res_par, err_cnt);
            else pass_cnt++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (res_valid !== 1'b0 || err_cnt !== 2'd2)
            $display("FAIL bp_release got v=%b cnt=%0d want 0/2", res_valid, err_cnt);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (err_cnt !== 2'd2) $display("FAIL bp_once got cnt=%0d want 2", err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt;
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk_cnt++;
        if (err_cnt !== 2'd0 || err_sticky !== 1'b0)
            $display("FAIL sat_preclr got cnt=%0d sticky=%b want 0/0", err_cnt, err_sticky);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            send(8'h01, 1'b0);
            @(negedge clk);
            exp_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
            chk_cnt++;
            if (err_cnt !== exp_cnt)
                $display("FAIL sat_cnt word %0d got %0d want %0d", k, err_cnt, exp_cnt);
            else pass_cnt++;
        end
        send(8'h01, 1'b0);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk_cnt++;
        if (err_cnt !== 2'd1 || err_sticky !== 1'b1)
            $display("FAIL sat_clr_vs_err got cnt=%0d sticky=%b want 1/1", err_cnt, err_sticky);
        else pass_cnt++;
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk_cnt++;
        if (err_cnt !== 2'd0 || err_sticky !== 1'b0)
            $display("FAIL sat_lone_clr got cnt=%0d sticky=%b want 0/0", err_cnt, err_sticky);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        send(8'h01, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            sum_bit  = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_err !== 1'b0 || res_par !== 1'b0)
            $display("FAIL rmid_outputs got rdy=%b v=%b err=%b par=%b want 1/0/0/0",
                     in_ready, res_valid, res_err, res_par);
        else pass_cnt++;
        chk_cnt++;
        if (err_cnt !== 2'd0 || err_sticky !== 1'b0)
            $display("FAIL rmid_cnt got cnt=%0d sticky=%b want 0/0", err_cnt, err_sticky);
        else pass_cnt++;
        #1 rst = 1'b0;
        send(8'hFF, 1'b0);
        chk_cnt++;
        if (res_valid !== 1'b1 || res_err !== 1'b0 || res_par !== 1'b0)
            $display("FAIL rmid_word got v=%b err=%b par=%b want 1/0/0",
                     res_valid, res_err, res_par);
        else pass_cnt++;
        @(negedge clk);
    endtask

`ifdef PARITY_SUM_CHECKER_FIRST_ERR_EN
    // Word 0 was the 0xFF word sent right after the mid-word reset.
    task automatic test_first_err;
        for (int n = 1; n <= 6; n++) begin
            if (n == 4 || n == 6) send(8'h01, 1'b0);
            else send(8'h5A, 1'b0);
            @(negedge clk);
        end
        chk_cnt++;
        if (first_err_word !== 2'(4))
            $display("FAIL first_err_a got %0d want %0d", first_err_word, 2'(4));
        else pass_cnt++;
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        for (int n = 7; n <= 9; n++) begin
            if (n == 9) send(8'h01, 1'b0);
            else send(8'h5A, 1'b0);
            @(negedge clk);
        end
        chk_cnt++;
        if (first_err_word !== 2'(9))
            $display("FAIL first_err_b got %0d want %0d", first_err_word, 2'(9));
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_correct();
        test_stall();
        test_mismatch();
        test_back_pressure();
        test_saturation();
        test_reset_mid();
`ifdef PARITY_SUM_CHECKER_FIRST_ERR_EN
        test_first_err();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
